// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   NOP_INSTR      encoding presented alongside a misaligned-target trap entry
//   fetch_state_t  fetch control state {BOOT, FETCH, DRAIN}
//   fetch_entry_t  one buffered instruction {pc, instr}
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with a flush input.
//   clk, reset_n  clock, asynchronous active-low reset
//   flush         empties the FIFO; wins over push/pop in the same cycle
//   push/push_data  write when not full (or when a pop frees a slot that cycle)
//   pop           drop the head entry; ignored when empty
//   head_data     current head entry (storage is reset to zero)
//   empty, count  status
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count     = wr_ptr - rd_ptr;
    assign empty     = (count == '0);
    assign full      = (count == (AW + 1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch stage. Owns the PC, issues in-order
// instruction-memory requests, buffers returned words and presents
// {pc, instr} to decode.
//   pc_out / pc_seq_in          PC to the external +4 adder and its sum back
//   redirect_valid/redirect_pc  taken branch/jump, single-cycle pulse, highest priority
//   imem_req_*                  request channel (address = pc_out)
//   imem_rsp_*                  in-order response words
//   if_valid/if_ready/if_pc/if_instr  decode channel
//   if_misalign                 only with FETCH_MISALIGN_TRAP_EN defined
//   dbg_state                   current control state, for observation
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. Without it, the low two
// bits of redirect_pc are forced to zero.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A producer holds valid and its payload stable until the transfer, except
// that a redirect may withdraw a pending fetch request.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          BUF_DEPTH    = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    output logic [31:0]  pc_out,
    input  logic [31:0]  pc_seq_in,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [31:0]  imem_req_addr,
    input  logic         imem_rsp_valid,
    input  logic [31:0]  imem_rsp_data,
    output logic         if_valid,
    input  logic         if_ready,
    output logic [31:0]  if_pc,
    output logic [31:0]  if_instr,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic         if_misalign,
`endif
    output fetch_state_t dbg_state
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t  state;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] live_out;
    logic [CW-1:0] buf_count;
    logic          buf_empty;
    logic          buf_push;
    logic          buf_pop;
    fetch_entry_t  buf_head;
    logic [31:0]   addr_head;
    logic          accept;
    logic          rsp_take;
    logic [31:0]   redir_target;
    logic          stall;
    logic          mis_pending;
    logic          addr_fifo_empty_unused;
    logic [CW-1:0] addr_fifo_count_unused;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic redir_mis;
    assign redir_mis    = |redirect_pc[1:0];
    assign redir_target = redirect_pc;

    // A misaligned target yields one trap entry and then parks fetch until
    // the next redirect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall       <= 1'b0;
            mis_pending <= 1'b0;
        end else if (redirect_valid) begin
            stall       <= redir_mis;
            mis_pending <= redir_mis;
        end else if (mis_pending && if_ready) begin
            mis_pending <= 1'b0;
        end
    end
    assign if_misalign = mis_pending;
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redir_target = {redirect_pc[31:2], 2'b00};
    assign stall        = 1'b0;
    assign mis_pending  = 1'b0;
`endif

    // Request only while in-flight words are guaranteed a buffer slot.
    assign imem_req_valid = (state == FETCH) && !stall &&
                            ((int'(out_cnt) + int'(buf_count)) < BUF_DEPTH);
    assign imem_req_addr  = pc_out;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_take       = imem_rsp_valid && (out_cnt != '0);
    // Outstanding count as of the coming edge; also the drop count on redirect.
    assign live_out       = out_cnt + CW'(accept) - CW'(rsp_take);

    assign buf_push  = rsp_take && (state == FETCH) && !redirect_valid;
    assign buf_pop   = if_ready && !buf_empty && !mis_pending;

    assign if_valid  = mis_pending || !buf_empty;
    assign if_pc     = mis_pending ? pc_out    : buf_head.pc;
    assign if_instr  = mis_pending ? NOP_INSTR : buf_head.instr;
    assign dbg_state = state;

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH)) u_instr_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (buf_push),
        .push_data ({addr_head, imem_rsp_data}),
        .pop       (buf_pop),
        .head_data (buf_head),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    // Addresses of live requests, matched in order to returning words.
    fetch_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_addr_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (accept && !redirect_valid),
        .push_data (pc_out),
        .pop       (buf_push),
        .head_data (addr_head),
        .empty     (addr_fifo_empty_unused),
        .count     (addr_fifo_count_unused)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= BOOT;
            pc_out   <= RESET_VECTOR;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            out_cnt <= live_out;
            if (redirect_valid) begin
                pc_out <= redir_target;
                // Anything still in flight (including a request accepted this
                // very cycle) belongs to the old path and must be discarded.
                if (state != BOOT && live_out != '0) begin
                    state    <= DRAIN;
                    drop_cnt <= live_out;
                end else begin
                    state    <= FETCH;
                    drop_cnt <= '0;
                end
            end else begin
                if (accept) begin
                    pc_out <= pc_seq_in;
                end
                case (state)
                    BOOT:  state <= FETCH;
                    FETCH: state <= FETCH;
                    DRAIN: begin
                        if (rsp_take) begin
                            drop_cnt <= drop_cnt - CW'(1);
                            if (drop_cnt == CW'(1)) begin
                                state <= FETCH;
                            end
                        end
                    end
                    default: state <= BOOT;
                endcase
            end
        end
    end

endmodule
